simple_dma_mem_target: RTL and testbench
========================================

# simple_dma_mem_target

Memory-side burst target for `simple_dma_engine`. It sits directly downstream of the engine's `m_*` master port and holds a word-addressed local memory. It serves read bursts and accepts write bursts, and it drives the 2-bit completion/error response the engine samples at the end of each burst.

## Interface
Parameters:
- `DEPTH_WORDS`, default 256: number of 32-bit words in local memory; power of two, max 4096.
- `BASE_ADDR`, default 32'h1000_0000: byte address of word 0; aligned to `DEPTH_WORDS*4`.

Ports:
- `clk  in  1`: single clock, rising edge.
- `rstn  in  1`: reset; synchronous, active-low.
- `m_addr  in  32`: burst start byte address, from the engine.
- `m_wdata  in  32`: write beat data.
- `m_rdata  out  32`: read beat data.
- `m_wenable  in  1`: write burst request, held high for the whole burst.
- `m_renable  in  1`: read burst request, held high for the whole burst.
- `m_wsize  in  12`: write burst size in bits; beats = `m_wsize[11:5]`.
- `m_rsize  in  12`: read burst size in bits; beats = `m_rsize[11:5]`.
- `m_err  out  2`: response; bit0 = done, bit1 = error. 00 pending, 01 OK, 11 error.

## Operation
- States: IDLE, RD, WR, ERR_RESP.
- Burst edges: E1 is the first rising edge at which an enable is sampled high in IDLE. E1 latches `base_idx = (m_addr - BASE_ADDR) >> 2` and `beats` from the matching size input. E2, E3, … are the following edges.
- Validity check at E1. The burst is in error if any of these hold:
  - `m_addr[1:0] != 0`
  - `m_addr < BASE_ADDR`
  - `beats == 0`
  - `base_idx + beats > DEPTH_WORDS`
  - both enables are high
- A valid burst goes to RD or WR. An invalid burst goes to ERR_RESP with no memory access.
- RD:
  - `m_rdata` is an asynchronous read.
  - Word `base_idx` is presented in the cycle before E1, decoded directly from `m_addr` while in IDLE with `m_renable` high.
  - Word `base_idx + k` is presented in the cycle after E_k.
  - The engine captures at E1..E_beats.
- WR: at E_k for k = 2..beats+1, write `mem[base_idx + k - 2] <= m_wdata`. There are no writes at E1 or after beats+1.
- Response:
  - `m_err` is registered.
  - Valid burst: `m_err <= 2'b01` at E_beats.
  - ERR_RESP: `m_err <= 2'b11` at E1.
  - Once set, the response is held while the enable stays high.
- Exit: at the first edge where the active enable is sampled low, the block returns to IDLE and `m_err <= 2'b00`. Only then can a new burst start (next E1).
- Abort: if the enable drops before E_beats, the block returns to IDLE and `m_err` = 00. Writes already performed are kept.
- Enable switch mid-burst (for example, `m_wenable` rising while in RD): ignored until IDLE.
- `m_rdata` = 0 when not in RD, not in IDLE with `m_renable` high, and on any error burst.

## Timing
- Reset, synchronous, and also when asserted mid-burst:
  - state = IDLE
  - `m_err` = 2'b00
  - counters = 0
  - `m_rdata` follows its rule above, so it is 0 with enables low
  - memory contents are not reset
- Read latency: zero-cycle combinational data per beat. Beat pointer advances one word per edge.
- Write: one word per edge, lagging the enable by one edge.
- `m_err` = 01 is visible in the cycle after E_beats and is sampled by the engine at E_beats+1.
- Edge counter: 7 bits, saturating at 127. Comparisons against `beats` are 7-bit unsigned.
- Index arithmetic: performed at 13 bits so that `base_idx + beats` cannot wrap.

## Structure
- `simple_dma_pkg`:
  - state enum
  - `DMA_RESP_PENDING` = 2'b00, `DMA_RESP_OK` = 2'b01, `DMA_RESP_ERR` = 2'b11
  - `DMA_BEAT_SHIFT` = 5
  - shared by engine and target
- Sub-module `simple_dma_mem_array`: `DEPTH_WORDS` x 32 register array, one async read port, one sync write port.
- The target holds the FSM, counters and range check.

## Test plan
- Read, 4 beats: preload mem[0..3] = A0..A3; `m_addr` = 0x1000_0000, `m_rsize` = 128 → engine buffer A0..A3; `m_err` = 01 after E4; 00 one edge after `m_renable` falls.
- Write, 4 beats: `m_addr` = 0x1000_0010, data B0..B3 → mem[4..7] = B0..B3; mem[3] and mem[8] unchanged; `m_err` = 01 after E4.
- Out of range: `m_addr` = 0x1000_03F8, `m_wsize` = 128 (idx 254 + 4 > 256) → `m_err` = 11 after E1; no memory change; `m_rdata` = 0.
- Misaligned or zero size: `m_addr` = 0x1000_0002 → 11. `m_rsize` = 31 → 11.
- Abort: `m_wenable` dropped after E3 of an 8-beat write → mem[idx], mem[idx+1] written, rest unchanged, `m_err` = 00.
- Reset mid-read at E2 → `m_err` = 00 and IDLE next cycle; a following valid 2-beat read completes normally with 01.

Source files
------------

// File: rtl/simple_dma_pkg.sv
// Shared definitions for the simple DMA engine and its memory-side target.
// Contents: FSM state encoding, response codes and the beat/size shift.
package simple_dma_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_RD       = 2'd1,
      ST_WR       = 2'd2,
      ST_ERR_RESP = 2'd3
   } dma_state_e;

   localparam logic [1:0] DMA_RESP_PENDING = 2'b00;
   localparam logic [1:0] DMA_RESP_OK      = 2'b01;
   localparam logic [1:0] DMA_RESP_ERR     = 2'b11;

   // Burst sizes are given in bits; beats = size >> DMA_BEAT_SHIFT (32-bit words).
   localparam int DMA_BEAT_SHIFT = 5;

endpackage

// File: rtl/simple_dma_mem_array.sv
// Word-addressed local storage for the DMA memory target.
// Ports:
//   clk       - clock, rising edge
//   i_we      - write enable for this edge
//   i_waddr   - write word index
//   i_wdata   - write data
//   i_raddr   - read word index (asynchronous read)
//   o_rdata   - read data
// Contents are never reset.
module simple_dma_mem_array #(
   parameter int unsigned DEPTH_WORDS = 256,
   parameter int unsigned AW          = 8
) (
   input  logic          clk,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [31:0]   i_wdata,
   input  logic [AW-1:0] i_raddr,
   output logic [31:0]   o_rdata
);

   logic [31:0] r_mem [DEPTH_WORDS];

   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/simple_dma_mem_target.sv
// Memory-side burst target for simple_dma_engine. Serves read bursts with
// combinational data, accepts write bursts lagging the enable by one edge,
// and drives a registered done/error response.
// Ports:
//   clk, rstn            - clock, synchronous active-low reset
//   m_addr               - burst start byte address
//   m_wdata / m_rdata    - write beat data in / read beat data out
//   m_wenable/m_renable  - burst requests, held for the whole burst
//   m_wsize / m_rsize    - burst sizes in bits (beats = size[11:5])
//   m_err                - response: 00 pending, 01 OK, 11 error
//   o_dbg_state          - current FSM state
module simple_dma_mem_target
   import simple_dma_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 256,
   parameter logic [31:0] BASE_ADDR   = 32'h1000_0000
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic [31:0] m_addr,
   input  logic [31:0] m_wdata,
   output logic [31:0] m_rdata,
   input  logic        m_wenable,
   input  logic        m_renable,
   input  logic [11:0] m_wsize,
   input  logic [11:0] m_rsize,
   output logic [1:0]  m_err,
   output logic [1:0]  o_dbg_state
);

   localparam int unsigned AW      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [12:0] DEPTH13 = 13'(DEPTH_WORDS);

   dma_state_e  r_state, w_state_nxt;
   logic [6:0]  r_cnt, w_cnt_nxt, w_cnt_inc;
   logic [12:0] r_base_idx, w_base_nxt;
   logic [6:0]  r_beats, w_beats_nxt;
   logic [1:0]  r_err, w_err_nxt;
   logic        r_wdone, w_wdone_nxt;

   logic [29:0] w_off;
   logic [12:0] w_req_idx;
   logic [6:0]  w_req_beats;
   logic        w_req_bad;
   logic        w_we;
   logic [12:0] w_widx, w_ridx;
   logic        w_rd_en;
   logic [31:0] w_mem_rdata;
   logic        w_unused_bits;

   assign w_unused_bits = ^{m_wsize[4:0], m_rsize[4:0]};

   // Request decode, used both for the pre-E1 read word and the E1 check.
   // BASE_ADDR is aligned, so subtracting word addresses gives the word offset.
   assign w_off       = m_addr[31:2] - BASE_ADDR[31:2];
   assign w_req_idx   = w_off[12:0];
   assign w_req_beats = m_wenable ? m_wsize[11:DMA_BEAT_SHIFT] : m_rsize[11:DMA_BEAT_SHIFT];
   // The explicit offset bound keeps a far-out address from aliasing into
   // range once truncated to 13 bits.
   assign w_req_bad   = (m_addr[1:0] != 2'b00) ||
                        (m_addr < BASE_ADDR) ||
                        (w_off >= 30'(DEPTH_WORDS)) ||
                        (w_req_beats == 7'd0) ||
                        (({6'd0, w_req_beats} + w_req_idx) > DEPTH13) ||
                        (m_wenable && m_renable);

   assign w_cnt_inc = (r_cnt == 7'h7F) ? r_cnt : r_cnt + 7'd1;

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_base_nxt  = r_base_idx;
      w_beats_nxt = r_beats;
      w_err_nxt   = r_err;
      w_wdone_nxt = r_wdone;
      w_we        = 1'b0;
      // Before E_k the counter holds k-1, so E_k writes word base + k - 2.
      w_widx      = r_base_idx + {6'd0, r_cnt} - 13'd1;
      w_ridx      = w_req_idx;
      w_rd_en     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_rd_en = m_renable && !w_req_bad;
            if (m_renable || m_wenable) begin
               w_base_nxt  = w_req_idx;
               w_beats_nxt = w_req_beats;
               w_cnt_nxt   = 7'd1;
               w_wdone_nxt = 1'b0;
               if (w_req_bad) begin
                  w_state_nxt = ST_ERR_RESP;
                  w_err_nxt   = DMA_RESP_ERR;
               end else begin
                  w_state_nxt = m_wenable ? ST_WR : ST_RD;
                  if (w_req_beats == 7'd1) begin
                     w_err_nxt = DMA_RESP_OK;
                  end
               end
            end
         end
         ST_RD: begin
            // After E_k the counter holds k, presenting word base + k.
            w_ridx = r_base_idx + {6'd0, r_cnt};
            w_rd_en = (w_ridx < DEPTH13);
            if (!m_renable) begin
               w_state_nxt = ST_IDLE;
               w_err_nxt   = DMA_RESP_PENDING;
               w_cnt_nxt   = 7'd0;
            end else begin
               w_cnt_nxt = w_cnt_inc;
               if (w_cnt_inc == r_beats) begin
                  w_err_nxt = DMA_RESP_OK;
               end
            end
         end
         ST_WR: begin
            if (!m_wenable) begin
               w_state_nxt = ST_IDLE;
               w_err_nxt   = DMA_RESP_PENDING;
               w_cnt_nxt   = 7'd0;
            end else begin
               // r_wdone stops a repeat write once the counter saturates.
               if ((r_cnt <= r_beats) && !r_wdone) begin
                  w_we = 1'b1;
                  if (r_cnt == r_beats) begin
                     w_wdone_nxt = 1'b1;
                  end
               end
               w_cnt_nxt = w_cnt_inc;
               if (w_cnt_inc == r_beats) begin
                  w_err_nxt = DMA_RESP_OK;
               end
            end
         end
         ST_ERR_RESP: begin
            if (!m_renable && !m_wenable) begin
               w_state_nxt = ST_IDLE;
               w_err_nxt   = DMA_RESP_PENDING;
               w_cnt_nxt   = 7'd0;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_err_nxt   = DMA_RESP_PENDING;
            w_cnt_nxt   = 7'd0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_state    <= ST_IDLE;
         r_cnt      <= 7'd0;
         r_base_idx <= 13'd0;
         r_beats    <= 7'd0;
         r_err      <= DMA_RESP_PENDING;
         r_wdone    <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_cnt      <= w_cnt_nxt;
         r_base_idx <= w_base_nxt;
         r_beats    <= w_beats_nxt;
         r_err      <= w_err_nxt;
         r_wdone    <= w_wdone_nxt;
      end
   end

   simple_dma_mem_array #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .AW          (AW)
   ) u_mem (
      .clk     (clk),
      .i_we    (w_we && rstn),
      .i_waddr (w_widx[AW-1:0]),
      .i_wdata (m_wdata),
      .i_raddr (w_ridx[AW-1:0]),
      .o_rdata (w_mem_rdata)
   );

   assign m_rdata     = w_rd_en ? w_mem_rdata : 32'd0;
   assign m_err       = r_err;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_simple_dma_mem_target.sv
// Directed bench for simple_dma_mem_target. Inputs change on the falling
// edge; outputs are sampled on the falling edge (registered ones reflect the
// preceding rising edge).
module tb_simple_dma_mem_target;
   import simple_dma_pkg::*;

   localparam logic [31:0] BASE = 32'h1000_0000;

   logic        clk = 1'b0;
   logic        rstn;
   logic [31:0] m_addr;
   logic [31:0] m_wdata;
   logic [31:0] m_rdata;
   logic        m_wenable;
   logic        m_renable;
   logic [11:0] m_wsize;
   logic [11:0] m_rsize;
   logic [1:0]  m_err;
   logic [1:0]  dbg_state;

   int n_tests = 0;
   int n_fail  = 0;
   logic [31:0] exp_buf [8];

   always #5 clk = ~clk;

   simple_dma_mem_target #(
      .DEPTH_WORDS (256),
      .BASE_ADDR   (BASE)
   ) dut (
      .clk         (clk),
      .rstn        (rstn),
      .m_addr      (m_addr),
      .m_wdata     (m_wdata),
      .m_rdata     (m_rdata),
      .m_wenable   (m_wenable),
      .m_renable   (m_renable),
      .m_wsize     (m_wsize),
      .m_rsize     (m_rsize),
      .m_err       (m_err),
      .o_dbg_state (dbg_state)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Write burst of 'beats' words seed+0.. starting at addr, held through E_beats+1.
   task automatic wr_burst(input logic [31:0] addr, input int beats, input logic [31:0] seed,
                           input string tag);
      @(negedge clk);
      m_addr    = addr;
      m_wsize   = 12'(beats * 32);
      m_wdata   = 32'hDEAD_BEEF;
      m_wenable = 1'b1;
      for (int k = 1; k <= beats + 1; k++) begin
         @(negedge clk);
         m_wdata = seed + 32'(k - 1);
         check($sformatf("%s err after E%0d", tag, k), {30'd0, m_err},
               (k >= beats) ? 32'd1 : 32'd0);
      end
      m_wenable = 1'b0;
      @(negedge clk);
      check({tag, " err after drop"}, {30'd0, m_err}, 32'd0);
   endtask

   // Read burst, comparing every presented beat against exp_buf.
   task automatic rd_burst(input logic [31:0] addr, input int beats, input string tag);
      @(negedge clk);
      m_addr    = addr;
      m_rsize   = 12'(beats * 32);
      m_renable = 1'b1;
      #1;
      check({tag, " beat0"}, m_rdata, exp_buf[0]);
      for (int k = 1; k <= beats; k++) begin
         @(negedge clk);
         if (k < beats) check($sformatf("%s beat%0d", tag, k), m_rdata, exp_buf[k]);
         check($sformatf("%s err after E%0d", tag, k), {30'd0, m_err},
               (k == beats) ? 32'd1 : 32'd0);
      end
      m_renable = 1'b0;
      @(negedge clk);
      check({tag, " err after drop"}, {30'd0, m_err}, 32'd0);
      check({tag, " idle after drop"}, {30'd0, dbg_state}, 32'(ST_IDLE));
   endtask

   // Burst expected to be rejected at E1.
   task automatic err_burst(input logic [31:0] addr, input logic wen, input logic ren,
                            input logic [11:0] wsize, input logic [11:0] rsize, input string tag);
      @(negedge clk);
      m_addr    = addr;
      m_wsize   = wsize;
      m_rsize   = rsize;
      m_wdata   = 32'hBAD0_BAD0;
      m_wenable = wen;
      m_renable = ren;
      #1;
      check({tag, " rdata pre-E1"}, m_rdata, 32'd0);
      @(negedge clk);
      check({tag, " err after E1"}, {30'd0, m_err}, 32'd3);
      check({tag, " state after E1"}, {30'd0, dbg_state}, 32'(ST_ERR_RESP));
      check({tag, " rdata in err"}, m_rdata, 32'd0);
      @(negedge clk);
      check({tag, " err held"}, {30'd0, m_err}, 32'd3);
      m_wenable = 1'b0;
      m_renable = 1'b0;
      @(negedge clk);
      check({tag, " err after drop"}, {30'd0, m_err}, 32'd0);
   endtask

   initial begin
      rstn = 1'b0; m_addr = 32'd0; m_wdata = 32'd0; m_wenable = 1'b0; m_renable = 1'b0;
      m_wsize = 12'd0; m_rsize = 12'd0;
      repeat (3) @(negedge clk);
      check("reset err", {30'd0, m_err}, 32'd0);
      check("reset state", {30'd0, dbg_state}, 32'(ST_IDLE));
      check("reset rdata", m_rdata, 32'd0);
      rstn = 1'b1;

      // Known background in words 0..15, then the 4-beat write/read pair.
      wr_burst(BASE, 16, 32'hC0DE_0000, "pre16");
      wr_burst(BASE, 4, 32'hA000_0000, "wrA");
      for (int i = 0; i < 4; i++) exp_buf[i] = 32'hA000_0000 + 32'(i);
      rd_burst(BASE, 4, "rdA");

      // Write words 4..7, then read 3..8 to see both neighbours untouched.
      wr_burst(BASE + 32'h10, 4, 32'hB000_0000, "wrB");
      exp_buf[0] = 32'hA000_0003;
      for (int i = 0; i < 4; i++) exp_buf[i + 1] = 32'hB000_0000 + 32'(i);
      exp_buf[5] = 32'hC0DE_0008;
      rd_burst(BASE + 32'hC, 6, "rdB");

      // Last two words of memory: exactly in range.
      wr_burst(BASE + 32'h3F8, 2, 32'hD000_0000, "wrTop");
      err_burst(BASE + 32'h3F8, 1'b1, 1'b0, 12'd128, 12'd0, "oor");
      exp_buf[0] = 32'hD000_0000;
      exp_buf[1] = 32'hD000_0001;
      rd_burst(BASE + 32'h3F8, 2, "rdTop");

      err_burst(BASE + 32'h2, 1'b0, 1'b1, 12'd0, 12'd128, "misalign");
      err_burst(BASE, 1'b0, 1'b1, 12'd0, 12'd31, "zero");
      err_burst(BASE - 32'h10, 1'b0, 1'b1, 12'd0, 12'd64, "below");
      err_burst(BASE, 1'b1, 1'b1, 12'd64, 12'd64, "both");

      // Abort an 8-beat write at word 8 after E3: only words 8 and 9 change.
      @(negedge clk);
      m_addr = BASE + 32'h20; m_wsize = 12'd256; m_wenable = 1'b1;
      @(negedge clk);
      m_wdata = 32'hE000_0000;
      @(negedge clk);
      m_wdata = 32'hE000_0001;
      @(negedge clk);
      check("abort err before drop", {30'd0, m_err}, 32'd0);
      m_wenable = 1'b0; m_wdata = 32'hE000_0002;
      @(negedge clk);
      check("abort err", {30'd0, m_err}, 32'd0);
      check("abort state", {30'd0, dbg_state}, 32'(ST_IDLE));
      exp_buf[0] = 32'hE000_0000;
      exp_buf[1] = 32'hE000_0001;
      exp_buf[2] = 32'hC0DE_000A;
      rd_burst(BASE + 32'h20, 3, "rdAbort");

      // Reset sampled at E2 of a 4-beat read.
      @(negedge clk);
      m_addr = BASE; m_rsize = 12'd128; m_renable = 1'b1;
      @(negedge clk);
      check("rst-rd beat1", m_rdata, 32'hA000_0001);
      check("rst-rd state", {30'd0, dbg_state}, 32'(ST_RD));
      rstn = 1'b0;
      @(negedge clk);
      check("rst-rd err", {30'd0, m_err}, 32'd0);
      check("rst-rd idle", {30'd0, dbg_state}, 32'(ST_IDLE));
      m_renable = 1'b0; rstn = 1'b1;

      // Reset while holding an error response.
      @(negedge clk);
      m_addr = BASE + 32'h1; m_rsize = 12'd64; m_renable = 1'b1;
      @(negedge clk);
      check("rst-err err set", {30'd0, m_err}, 32'd3);
      rstn = 1'b0;
      @(negedge clk);
      check("rst-err err cleared", {30'd0, m_err}, 32'd0);
      m_renable = 1'b0; rstn = 1'b1;

      exp_buf[0] = 32'hB000_0000;
      exp_buf[1] = 32'hB000_0001;
      rd_burst(BASE + 32'h10, 2, "rdPostRst");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
